song_event_scheduler: RTL and testbench
=======================================

# song_event_scheduler

Sequences playback of a stored song against the microsecond time base. It owns the time counter's enable and clear controls and fetches note events from a synchronous song ROM. When the microsecond count reaches each event's timestamp, it issues that event to the note consumer over a valid/ready handshake. It sits between the top-level game control (start/pause/abort), the microsecond time counter, and the note/audio consumer.

## Interface
- ADDR_W, 8, song ROM address width (max 2^ADDR_W events)
- TIME_W, 29, microsecond timestamp width (matches time counter)
- NOTE_W, 5, note code width
- clk  in  1  system clock
- resetn  in  1  asynchronous, active-low reset
- start  in  1  level; begin playback from IDLE/DONE, resume from PAUSED
- pause  in  1  level; request pause
- abort  in  1  level; return to IDLE, clear time base
- now_us  in  TIME_W  current microsecond count from time counter
- timer_enable  out  1  enable to time counter
- timer_clear  out  1  active-high one-cycle clear to time counter
- rom_addr  out  ADDR_W  song ROM address
- rom_data  in  TIME_W+NOTE_W+1  {last, note, time_us}; valid 1 cycle after rom_addr
- evt_valid  out  1  event available
- evt_ready  in  1  consumer accepts event
- evt_note  out  NOTE_W  note code of issued event
- evt_time  out  TIME_W  scheduled timestamp of issued event
- busy  out  1  state not IDLE/DONE
- done  out  1  high in DONE
- overrun  out  1  sticky; time base wrapped before song end

## Operation
- States: IDLE, CLEAR, FETCH, LOAD, ARMED, ISSUE, PAUSED, DONE.
- IDLE: start -> CLEAR.
- CLEAR: timer_clear=1 for exactly this cycle; rom_addr<=0; overrun<=0 -> FETCH.
- FETCH: rom_addr presented -> LOAD.
- LOAD: capture rom_data into evt_time/evt_note/last_q -> ARMED.
- ARMED: if now_us >= evt_time -> ISSUE.
- ISSUE: evt_valid=1; evt_note/evt_time stable until handshake. On evt_valid&&evt_ready: if last_q -> DONE, else rom_addr+1 -> FETCH.
- PAUSED: timer_enable=0; start -> FETCH (re-reads current rom_addr).
- DONE: done=1, timer_enable=0; start -> CLEAR.
- timer_enable=1 in FETCH, LOAD, ARMED, ISSUE; 0 otherwise.
- pause is latched into pause_pend in any busy state. It is acted on only on entry into ARMED, or in ARMED, and goes to PAUSED. It is never taken inside ISSUE, so an offered event is never withdrawn. pause_pend is cleared on entry to PAUSED.
- abort in any state -> IDLE next cycle, with timer_clear=1 that cycle. It drops evt_valid and clears pause_pend.
- Priority when simultaneous: abort > pause > start.
- Late events (now_us already past evt_time in LOAD): ARMED exits the next cycle; no catch-up skipping.
- Wrap: now_us_q holds the previous now_us. If now_us < now_us_q while timer_enable=1 and the state is not CLEAR, then overrun<=1 and go to DONE.
- rom_addr increment wraps modulo 2^ADDR_W. The ROM must mark the last event.

## Timing
- Reset values: state IDLE, timer_enable 0, timer_clear 0, rom_addr 0, evt_valid 0, evt_note 0, evt_time 0, busy 0, done 0, overrun 0.
- start to timer_clear: 1 cycle (the CLEAR state).
- Fetch latency: 2 cycles (FETCH, LOAD) before compare.
- Compare to evt_valid: now_us>=evt_time sampled in ARMED; evt_valid rises the next cycle.
- Handshake to next event armed: 3 cycles (FETCH, LOAD, ARMED).
- Minimum inter-event spacing is therefore 4 cycles; events closer than that issue late.
- All outputs are registered.

## Structure
- Shared package: state encoding localparams, ROM field offsets (TIME_LSB=0, NOTE_LSB=TIME_W, LAST_BIT=TIME_W+NOTE_W), and the TIME_W default, which is also used by the time counter.
- Single module; no sub-module. The next-state logic and the datapath registers (address, event latch, now_us_q) live in one file.

## Test plan
- Basic: ROM {t=5,n=3},{t=10,n=7,last} with evt_ready=1. start -> one timer_clear pulse; evt_note=3 when now_us≥5, evt_note=7 when now_us≥10; then done=1 and timer_enable=0.
- Backpressure: evt_ready held 0 for 20 cycles in ISSUE -> evt_valid stays 1, evt_note/evt_time constant; accepted on the first cycle ready=1.
- Pause/resume: pause asserted during ISSUE -> PAUSED only after the handshake; timer_enable=0 while paused; start resumes and re-fetches rom_addr=1.
- Abort mid-song: abort at event 1 with evt_valid=1 -> next cycle state IDLE, evt_valid=0, timer_clear=1 for one cycle.
- Simultaneous: start, pause, abort high together in ARMED -> IDLE; pause and start together in ARMED -> PAUSED.
- Overrun: now_us steps 299999999 -> 0 while ARMED -> overrun=1, DONE; overrun cleared on the next start's CLEAR.

Source files
------------

// File: rtl/song_event_scheduler_pkg.sv
// Shared definitions for the song event scheduler and its neighbours.
//   - TIME_W_DEF : default microsecond timestamp width (also used by the time counter)
//   - NOTE_W_DEF : default note code width
//   - state_t    : scheduler state encoding
//   - ROM word layout {last, note, time_us}: TIME_LSB, NOTE_LSB, LAST_BIT
package song_event_scheduler_pkg;

  localparam int unsigned TIME_W_DEF = 29;
  localparam int unsigned NOTE_W_DEF = 5;

  // ROM field offsets for the default widths
  localparam int unsigned TIME_LSB = 0;
  localparam int unsigned NOTE_LSB = TIME_W_DEF;
  localparam int unsigned LAST_BIT = TIME_W_DEF + NOTE_W_DEF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FETCH,
    S_LOAD,
    S_ARMED,
    S_ISSUE,
    S_PAUSED,
    S_DONE
  } state_t;

  // Field offsets for non-default widths
  function automatic int unsigned note_lsb(input int unsigned time_w);
    return time_w;
  endfunction

  function automatic int unsigned last_bit(input int unsigned time_w, input int unsigned note_w);
    return time_w + note_w;
  endfunction

endpackage

// File: rtl/song_event_scheduler.sv
// Song playback scheduler. Fetches {last, note, time_us} events from a
// synchronous song ROM and offers each one to the note consumer over a
// valid/ready handshake once the microsecond time base reaches its timestamp.
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   start/pause/abort  level controls from game control (abort > pause > start)
//   now_us             current microsecond count
//   timer_enable       run enable to the time counter
//   timer_clear        one-cycle clear to the time counter
//   rom_addr/rom_data  song ROM port (data valid one cycle after address)
//   evt_valid/ready    event handshake; evt_note/evt_time hold the event
//   busy/done          playback activity / song finished
//   overrun            sticky: time base wrapped before the last event
module song_event_scheduler
  import song_event_scheduler_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned TIME_W = TIME_W_DEF,
  parameter int unsigned NOTE_W = NOTE_W_DEF
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       start,
  input  logic                       pause,
  input  logic                       abort,
  input  logic [TIME_W-1:0]          now_us,
  output logic                       timer_enable,
  output logic                       timer_clear,
  output logic [ADDR_W-1:0]          rom_addr,
  input  logic [TIME_W+NOTE_W:0]     rom_data,
  output logic                       evt_valid,
  input  logic                       evt_ready,
  output logic [NOTE_W-1:0]          evt_note,
  output logic [TIME_W-1:0]          evt_time,
  output logic                       busy,
  output logic                       done,
  output logic                       overrun
);

  localparam int unsigned NLSB = note_lsb(TIME_W);
  localparam int unsigned LBIT = last_bit(TIME_W, NOTE_W);

  state_t              state;
  state_t              nxt;
  logic                last_q;
  logic                pause_pend;
  logic [TIME_W-1:0]   now_us_q;
  logic                wrap;
  logic                pause_req;
  logic [TIME_W-1:0]   rom_time;
  logic [NOTE_W-1:0]   rom_note;
  logic                rom_last;

  assign rom_time = rom_data[TIME_LSB +: TIME_W];
  assign rom_note = rom_data[NLSB +: NOTE_W];
  assign rom_last = rom_data[LBIT];

  assign wrap      = timer_enable && (state != S_CLEAR) && (now_us < now_us_q);
  assign pause_req = pause_pend || pause;

  always_comb begin
    nxt = state;
    if (abort) begin
      nxt = S_IDLE;
    end else if (wrap) begin
      nxt = S_DONE;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (start) nxt = S_CLEAR;
        S_CLEAR:        nxt = S_FETCH;
        S_FETCH:        nxt = S_LOAD;
        // Pause is honoured only around ARMED so an offered event is never withdrawn
        S_LOAD:         nxt = pause_req ? S_PAUSED : S_ARMED;
        S_ARMED: begin
          if (pause_req)              nxt = S_PAUSED;
          else if (now_us >= evt_time) nxt = S_ISSUE;
        end
        S_ISSUE:        if (evt_ready) nxt = last_q ? S_DONE : S_FETCH;
        S_PAUSED:       if (start && !pause) nxt = S_FETCH;
        default:        nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= S_IDLE;
      timer_enable <= 1'b0;
      timer_clear  <= 1'b0;
      rom_addr     <= '0;
      evt_valid    <= 1'b0;
      evt_note     <= '0;
      evt_time     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      overrun      <= 1'b0;
      last_q       <= 1'b0;
      pause_pend   <= 1'b0;
      now_us_q     <= '0;
    end else begin
      state        <= nxt;
      timer_enable <= (nxt == S_FETCH) || (nxt == S_LOAD) || (nxt == S_ARMED) || (nxt == S_ISSUE);
      timer_clear  <= abort || (nxt == S_CLEAR);
      evt_valid    <= (nxt == S_ISSUE);
      busy         <= (nxt != S_IDLE) && (nxt != S_DONE);
      done         <= (nxt == S_DONE);

      // The counter reads zero once CLEAR ends; seeding the history with zero
      // keeps the stale pre-clear count from looking like a wrap in FETCH.
      now_us_q <= (state == S_CLEAR) ? '0 : now_us;

      if (state == S_CLEAR) begin
        rom_addr <= '0;
        overrun  <= 1'b0;
      end else begin
        if (!abort && wrap) overrun <= 1'b1;
        if (state == S_ISSUE && nxt == S_FETCH) rom_addr <= rom_addr + 1'b1;
      end

      if (state == S_LOAD) begin
        evt_time <= rom_time;
        evt_note <= rom_note;
        last_q   <= rom_last;
      end

      if (abort || nxt == S_PAUSED)
        pause_pend <= 1'b0;
      else if (pause && state != S_IDLE && state != S_DONE && state != S_PAUSED)
        pause_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_song_event_scheduler.sv
module tb_song_event_scheduler;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned TIME_W = 29;
  localparam int unsigned NOTE_W = 5;

  logic                  clk;
  logic                  resetn;
  logic                  start, pause, abort;
  logic [TIME_W-1:0]     now_us;
  logic                  timer_enable, timer_clear;
  logic [ADDR_W-1:0]     rom_addr;
  logic [TIME_W+NOTE_W:0] rom_data;
  logic                  evt_valid, evt_ready;
  logic [NOTE_W-1:0]     evt_note;
  logic [TIME_W-1:0]     evt_time;
  logic                  busy, done, overrun;

  logic [TIME_W+NOTE_W:0] rom [0:(1<<ADDR_W)-1];
  logic [TIME_W-1:0]     cnt;
  logic [TIME_W-1:0]     man_val;
  logic                  manual;

  int total = 0;
  int bad   = 0;

  song_event_scheduler #(.ADDR_W(ADDR_W), .TIME_W(TIME_W), .NOTE_W(NOTE_W)) dut (
    .clk(clk), .resetn(resetn), .start(start), .pause(pause), .abort(abort),
    .now_us(now_us), .timer_enable(timer_enable), .timer_clear(timer_clear),
    .rom_addr(rom_addr), .rom_data(rom_data), .evt_valid(evt_valid),
    .evt_ready(evt_ready), .evt_note(evt_note), .evt_time(evt_time),
    .busy(busy), .done(done), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous song ROM and a simple microsecond counter model
  always @(posedge clk) rom_data <= rom[rom_addr];

  always @(posedge clk) begin
    if (!resetn)           cnt <= '0;
    else if (timer_clear)  cnt <= '0;
    else if (timer_enable) cnt <= cnt + 1'b1;
  end

  assign now_us = manual ? man_val : cnt;

  function automatic logic [TIME_W+NOTE_W:0] mk(input logic last, input logic [NOTE_W-1:0] n,
                                                input logic [TIME_W-1:0] t);
    return {last, n, t};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int lim, output bit ok);
    int n = 0;
    while (!evt_valid && n < lim) begin
      tick();
      n++;
    end
    ok = evt_valid;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) tick();
    total++;
    if ({timer_enable, timer_clear, evt_valid, busy, done, overrun} !== 6'b0) begin
      bad++; $display("FAIL reset_flags: got %b want 000000",
                      {timer_enable, timer_clear, evt_valid, busy, done, overrun});
    end
    total++;
    if ({rom_addr, evt_note, evt_time} !== '0) begin
      bad++; $display("FAIL reset_data: addr=%0d note=%0d time=%0d want 0", rom_addr, evt_note, evt_time);
    end
    resetn = 1'b1;
    tick();
    total++;
    if (busy !== 1'b0 || timer_enable !== 1'b0) begin
      bad++; $display("FAIL reset_idle: busy=%b en=%b want 0 0", busy, timer_enable);
    end
  endtask

  task automatic test_basic();
    bit ok;
    rom[0] = mk(1'b0, 5'd3, 29'd5);
    rom[1] = mk(1'b1, 5'd7, 29'd10);
    evt_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if (timer_clear !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL basic_clear: clr=%b busy=%b want 1 1", timer_clear, busy);
    end
    tick();
    total++;
    if (timer_clear !== 1'b0 || timer_enable !== 1'b1 || rom_addr !== 8'd0) begin
      bad++; $display("FAIL basic_fetch: clr=%b en=%b addr=%0d want 0 1 0", timer_clear, timer_enable, rom_addr);
    end
    wait_valid(40, ok);
    total++;
    if (!ok || evt_note !== 5'd3 || evt_time !== 29'd5 || now_us !== 29'd6) begin
      bad++; $display("FAIL basic_ev0: valid=%b note=%0d time=%0d now=%0d want 1 3 5 6",
                      evt_valid, evt_note, evt_time, now_us);
    end
    tick();
    total++;
    if (evt_valid !== 1'b0) begin
      bad++; $display("FAIL basic_ev0_drop: valid=%b want 0", evt_valid);
    end
    wait_valid(40, ok);
    total++;
    if (!ok || evt_note !== 5'd7 || evt_time !== 29'd10 || now_us !== 29'd11) begin
      bad++; $display("FAIL basic_ev1: valid=%b note=%0d time=%0d now=%0d want 1 7 10 11",
                      evt_valid, evt_note, evt_time, now_us);
    end
    tick();
    total++;
    if (done !== 1'b1 || timer_enable !== 1'b0 || busy !== 1'b0 || evt_valid !== 1'b0) begin
      bad++; $display("FAIL basic_done: done=%b en=%b busy=%b valid=%b want 1 0 0 0",
                      done, timer_enable, busy, evt_valid);
    end
    evt_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    bit ok;
    int held_bad = 0;
    rom[0] = mk(1'b1, 5'd9, 29'd3);
    evt_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(40, ok);
    total++;
    if (!ok || evt_note !== 5'd9 || evt_time !== 29'd3) begin
      bad++; $display("FAIL bp_offer: valid=%b note=%0d time=%0d want 1 9 3", evt_valid, evt_note, evt_time);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      if (evt_valid !== 1'b1 || evt_note !== 5'd9 || evt_time !== 29'd3) held_bad++;
    end
    total++;
    if (held_bad != 0) begin
      bad++; $display("FAIL bp_hold: unstable cycles=%0d want 0", held_bad);
    end
    evt_ready = 1'b1;
    tick();
    total++;
    if (evt_valid !== 1'b0 || done !== 1'b1) begin
      bad++; $display("FAIL bp_accept: valid=%b done=%b want 0 1", evt_valid, done);
    end
    evt_ready = 1'b0;
  endtask

  task automatic test_pause_resume();
    bit ok;
    logic [TIME_W-1:0] t0;
    int n;
    rom[0] = mk(1'b0, 5'd1, 29'd2);
    rom[1] = mk(1'b0, 5'd2, 29'd4);
    rom[2] = mk(1'b1, 5'd4, 29'd6);
    evt_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(40, ok);
    total++;
    if (!ok || evt_note !== 5'd1) begin
      bad++; $display("FAIL pr_ev0: valid=%b note=%0d want 1 1", evt_valid, evt_note);
    end
    pause = 1'b1;
    tick();
    pause = 1'b0;
    total++;
    if (evt_valid !== 1'b1) begin
      bad++; $display("FAIL pr_no_withdraw: valid=%b want 1", evt_valid);
    end
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    total++;
    if (evt_valid !== 1'b0 || rom_addr !== 8'd1 || timer_enable !== 1'b1) begin
      bad++; $display("FAIL pr_handshake: valid=%b addr=%0d en=%b want 0 1 1", evt_valid, rom_addr, timer_enable);
    end
    tick();
    tick();
    total++;
    if (timer_enable !== 1'b0 || busy !== 1'b1 || evt_valid !== 1'b0) begin
      bad++; $display("FAIL pr_paused: en=%b busy=%b valid=%b want 0 1 0", timer_enable, busy, evt_valid);
    end
    t0 = now_us;
    repeat (5) tick();
    total++;
    if (now_us !== t0 || timer_enable !== 1'b0) begin
      bad++; $display("FAIL pr_frozen: now=%0d en=%b want %0d 0", now_us, timer_enable, t0);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if (rom_addr !== 8'd1 || timer_enable !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL pr_resume: addr=%0d en=%b busy=%b want 1 1 1", rom_addr, timer_enable, busy);
    end
    evt_ready = 1'b1;
    wait_valid(40, ok);
    total++;
    if (!ok || evt_note !== 5'd2 || evt_time !== 29'd4) begin
      bad++; $display("FAIL pr_ev1: valid=%b note=%0d time=%0d want 1 2 4", evt_valid, evt_note, evt_time);
    end
    n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    total++;
    if (done !== 1'b1) begin
      bad++; $display("FAIL pr_done: done=%b want 1", done);
    end
    evt_ready = 1'b0;
  endtask

  task automatic test_abort();
    bit ok;
    rom[0] = mk(1'b0, 5'd5, 29'd3);
    rom[1] = mk(1'b1, 5'd6, 29'd100);
    evt_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(40, ok);
    total++;
    if (!ok || evt_note !== 5'd5) begin
      bad++; $display("FAIL ab_offer: valid=%b note=%0d want 1 5", evt_valid, evt_note);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total++;
    if (evt_valid !== 1'b0 || timer_clear !== 1'b1 || busy !== 1'b0 || timer_enable !== 1'b0) begin
      bad++; $display("FAIL ab_idle: valid=%b clr=%b busy=%b en=%b want 0 1 0 0",
                      evt_valid, timer_clear, busy, timer_enable);
    end
    tick();
    total++;
    if (timer_clear !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL ab_clr_once: clr=%b busy=%b want 0 0", timer_clear, busy);
    end
  endtask

  task automatic test_simultaneous();
    rom[0] = mk(1'b1, 5'd1, 29'd1000);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    start = 1'b1; pause = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; pause = 1'b0; abort = 1'b0;
    total++;
    if (busy !== 1'b0 || timer_clear !== 1'b1 || evt_valid !== 1'b0) begin
      bad++; $display("FAIL sim_abort_wins: busy=%b clr=%b valid=%b want 0 1 0", busy, timer_clear, evt_valid);
    end
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    start = 1'b1; pause = 1'b1;
    tick();
    pause = 1'b0;
    total++;
    if (timer_enable !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
      bad++; $display("FAIL sim_pause_wins: en=%b busy=%b done=%b want 0 1 0", timer_enable, busy, done);
    end
    tick();
    start = 1'b0;
    total++;
    if (timer_enable !== 1'b1) begin
      bad++; $display("FAIL sim_resume: en=%b want 1", timer_enable);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
  endtask

  task automatic test_overrun();
    manual = 1'b1;
    man_val = '0;
    rom[0] = mk(1'b1, 5'd3, 29'd400000000);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    man_val = 29'd299999999;
    tick();
    total++;
    if (overrun !== 1'b0 || busy !== 1'b1 || evt_valid !== 1'b0) begin
      bad++; $display("FAIL ov_before: ovr=%b busy=%b valid=%b want 0 1 0", overrun, busy, evt_valid);
    end
    man_val = '0;
    tick();
    total++;
    if (overrun !== 1'b1 || done !== 1'b1 || timer_enable !== 1'b0 || evt_valid !== 1'b0) begin
      bad++; $display("FAIL ov_wrap: ovr=%b done=%b en=%b valid=%b want 1 1 0 0",
                      overrun, done, timer_enable, evt_valid);
    end
    tick();
    total++;
    if (overrun !== 1'b1) begin
      bad++; $display("FAIL ov_sticky: ovr=%b want 1", overrun);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    total++;
    if (overrun !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL ov_cleared: ovr=%b busy=%b want 0 1", overrun, busy);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    manual = 1'b0;
  endtask

  initial begin
    resetn = 1'b0;
    start = 1'b0; pause = 1'b0; abort = 1'b0;
    evt_ready = 1'b0;
    manual = 1'b0;
    man_val = '0;
    for (int i = 0; i < (1 << ADDR_W); i++) rom[i] = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_pause_resume();
    test_abort();
    test_simultaneous();
    test_overrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

endmodule
